// File: rtl/rand_stim_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rand_stim_checker_pkg
// Description : Shared FSM state encoding and LFSR constants for the
//               random-stimulus fabric checker.
// Revision    : 1.0 - initial release
// ============================================================================
package rand_stim_checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Galois mask for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] C_LFSR_TAPS         = 32'h8020_0003;
   localparam logic [31:0] C_LFSR_SEED_DEFAULT = 32'h0000_0001;

endpackage : rand_stim_checker_pkg
`default_nettype wire

// File: rtl/rand_stim_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : rand_stim_lfsr
// Description : 32-bit right-shifting Galois LFSR with seed load and enable;
//               exposes its low STIM_WIDTH bits as the stimulus vector.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_stim_lfsr
   import rand_stim_checker_pkg::*;
#(
   parameter int          STIM_WIDTH = 1,
   parameter logic [31:0] SEED       = C_LFSR_SEED_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_load,
   input  logic                  i_en,
   output logic [STIM_WIDTH-1:0] o_stim
);

   logic [31:0] r_state;
   logic [31:0] w_next;

   always_comb begin
      w_next = {1'b0, r_state[31:1]};
      if (r_state[0]) begin
         w_next = w_next ^ C_LFSR_TAPS;
      end
   end

   // Load takes priority so a restart always begins from the seed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= SEED;
      end else if (i_load) begin
         r_state <= SEED;
      end else if (i_en) begin
         r_state <= w_next;
      end
   end

   assign o_stim = r_state[STIM_WIDTH-1:0];

endmodule : rand_stim_lfsr
`default_nettype wire

// File: rtl/rand_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : rand_stim_checker
// Description : Drives LFSR stimulus into fabric and reference, compares their
//               outputs after a warm-up and reports a sticky verdict.
// Revision    : 1.0 - initial release
// ============================================================================
module rand_stim_checker
   import rand_stim_checker_pkg::*;
#(
   parameter int          IN_WIDTH    = 1,
   parameter int          OUT_WIDTH   = 1,
   parameter int          CNT_WIDTH   = 16,
   parameter int          RUN_CYCLES  = 8192,
   parameter int          SKIP_CYCLES = 1,
   parameter int          COUNT_EDGES = 1,
   parameter logic [31:0] LFSR_SEED   = C_LFSR_SEED_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [OUT_WIDTH-1:0] out_gfpga,
   input  logic [OUT_WIDTH-1:0] out_bench,
   output logic [IN_WIDTH-1:0]  stim,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_WIDTH-1:0] err_count,
   output logic [OUT_WIDTH-1:0] err_flags,
   output logic [CNT_WIDTH-1:0] first_err_cycle
);

   localparam logic [CNT_WIDTH-1:0] C_RUN_LAST  = CNT_WIDTH'(RUN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] C_SKIP_LAST = CNT_WIDTH'(SKIP_CYCLES - 1);

   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_err_count;
   logic [OUT_WIDTH-1:0] r_err_flags;
   logic [CNT_WIDTH-1:0] r_first_err;
   logic                 r_prev_hit;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_pass;

   logic                 w_load;
   logic                 w_en;
   logic [OUT_WIDTH-1:0] w_mism;
   logic                 w_hit;
   logic                 w_inc;
   logic [CNT_WIDTH-1:0] w_err_next;

   assign w_load = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
   assign w_en   = (r_state == ST_SKIP) || (r_state == ST_RUN);
   assign w_mism = out_gfpga ^ out_bench;
   assign w_hit  = |w_mism;

   // Edge mode counts a mismatch burst once, on its first cycle.
   assign w_inc      = (COUNT_EDGES != 0) ? (w_hit & ~r_prev_hit) : w_hit;
   assign w_err_next = (w_inc && !(&r_err_count)) ? r_err_count + 1'b1 : r_err_count;

   rand_stim_lfsr #(
      .STIM_WIDTH (IN_WIDTH),
      .SEED       (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_load),
      .i_en   (w_en),
      .o_stim (stim)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_err_count <= '0;
         r_err_flags <= '0;
         r_first_err <= '0;
         r_prev_hit  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_cnt       <= '0;
                  r_err_count <= '0;
                  r_err_flags <= '0;
                  r_first_err <= '0;
                  r_prev_hit  <= 1'b0;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_state     <= (SKIP_CYCLES == 0) ? ST_RUN : ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (r_cnt == C_SKIP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               r_prev_hit  <= w_hit;
               r_err_count <= w_err_next;
               if (w_hit) begin
                  r_err_flags <= r_err_flags | w_mism;
                  if (r_err_count == '0) begin
                     r_first_err <= r_cnt;
                  end
               end
               if (r_cnt == C_RUN_LAST) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy            = r_busy;
   assign done            = r_done;
   assign pass            = r_pass;
   assign err_count       = r_err_count;
   assign err_flags       = r_err_flags;
   assign first_err_cycle = r_first_err;

endmodule : rand_stim_checker
`default_nettype wire

// File: tb/tb_rand_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_rand_stim_checker
// Description : Directed self-checking bench for rand_stim_checker using three
//               parameterisations driven from a shared start/reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rand_stim_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [3:0] f_a = 4'h0;
   logic [3:0] f_c = 4'h0;
   logic sat_mode = 1'b0;

   logic [3:0]  stim_a, stim_b, stim_c;
   logic [3:0]  gf_a, gf_b, gf_c;
   logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
   logic [15:0] cnt_a, first_a, cnt_b, first_b;
   logic [3:0]  cnt_c, first_c;
   logic [3:0]  flags_a, flags_b, flags_c;

   int total = 0;
   int bad = 0;
   int seq_busy;
   bit seq_ok;
   logic [3:0] fault_tab [0:15];
   logic [3:0] hist  [0:31];
   logic [3:0] hist1 [0:31];
   // low nibble of the LFSR from seed 1, one entry per busy cycle
   logic [3:0] exp_stim [0:7] = '{4'h1, 4'h3, 4'h2, 4'h1, 4'h3, 4'h2, 4'h1, 4'h3};

   always #5 clk = ~clk;

   assign gf_a = stim_a ^ f_a;
   assign gf_b = stim_b ^ f_a;
   assign gf_c = stim_c ^ f_c;

   rand_stim_checker #(.IN_WIDTH(4), .OUT_WIDTH(4), .CNT_WIDTH(16), .RUN_CYCLES(16),
                       .SKIP_CYCLES(2), .COUNT_EDGES(1), .LFSR_SEED(32'h1)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start), .out_gfpga(gf_a), .out_bench(stim_a),
      .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(cnt_a),
      .err_flags(flags_a), .first_err_cycle(first_a));

   rand_stim_checker #(.IN_WIDTH(4), .OUT_WIDTH(4), .CNT_WIDTH(16), .RUN_CYCLES(16),
                       .SKIP_CYCLES(2), .COUNT_EDGES(0), .LFSR_SEED(32'h1)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start), .out_gfpga(gf_b), .out_bench(stim_b),
      .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(cnt_b),
      .err_flags(flags_b), .first_err_cycle(first_b));

   rand_stim_checker #(.IN_WIDTH(4), .OUT_WIDTH(4), .CNT_WIDTH(4), .RUN_CYCLES(15),
                       .SKIP_CYCLES(2), .COUNT_EDGES(0), .LFSR_SEED(32'h1)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start), .out_gfpga(gf_c), .out_bench(stim_c),
      .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(cnt_c),
      .err_flags(flags_c), .first_err_cycle(first_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_faults();
      for (int i = 0; i < 16; i++) fault_tab[i] = 4'h0;
   endtask

   // Start a run; edge c+1 after the start edge samples RUN index k = c-2.
   task automatic run_sequence(input int start_k, input int stop_k);
      int k;
      seq_busy = 0;
      seq_ok   = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c < 32) hist[c] = stim_a;
         if (busy_a) seq_busy++;
         if (done_a) begin
            seq_ok = 1'b1;
            break;
         end
         k = c - 2;
         if (k == stop_k) begin
            seq_ok = 1'b1;
            break;
         end
         f_a   = (k >= 0 && k < 16) ? fault_tab[k] : 4'h0;
         f_c   = sat_mode ? 4'hF : 4'h0;
         start = (k == start_k);
         tick();
         start = 1'b0;
      end
      f_a = 4'h0;
      f_c = 4'h0;
      total++;
      if (!seq_ok) begin
         bad++;
         $display("FAIL run_timeout: done=%0b required 1", done_a);
      end
   endtask

   task automatic test_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      total++;
      if (busy_a !== 1'b1) begin bad++; $display("FAIL rst_pre_busy: got %0b required 1", busy_a); end
      rst_n = 1'b0;
      #2;
      total++;
      if ({busy_a, done_a, pass_a} !== 3'b000) begin
         bad++; $display("FAIL rst_flags: busy/done/pass=%b required 000", {busy_a, done_a, pass_a});
      end
      total++;
      if (cnt_a !== 16'd0 || stim_a !== 4'h1) begin
         bad++; $display("FAIL rst_vals: err_count=%0d stim=%h required 0 / 1", cnt_a, stim_a);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      total++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || stim_a !== 4'h1) begin
         bad++; $display("FAIL idle_hold: busy=%0b done=%0b stim=%h required 0 0 1", busy_a, done_a, stim_a);
      end
   endtask

   task automatic test_clean_run();
      logic [3:0] s_done;
      int nbad;
      clear_faults();
      run_sequence(-10, -10);
      total++;
      if (seq_busy != 18) begin bad++; $display("FAIL clean_busy_len: got %0d required 18", seq_busy); end
      total++;
      if ({done_a, pass_a} !== 2'b11 || cnt_a !== 16'd0 || flags_a !== 4'h0) begin
         bad++;
         $display("FAIL clean_verdict: done=%0b pass=%0b cnt=%0d flags=%b required 1 1 0 0000",
                  done_a, pass_a, cnt_a, flags_a);
      end
      nbad = 0;
      for (int i = 0; i < 8; i++) if (hist[i] !== exp_stim[i]) nbad++;
      total++;
      if (nbad != 0) begin
         bad++; $display("FAIL stim_seq: %0d of 8 wrong, first=%h required %h", nbad, hist[0], exp_stim[0]);
      end
      s_done = stim_a;
      repeat (3) tick();
      total++;
      if (done_a !== 1'b1 || stim_a !== s_done) begin
         bad++; $display("FAIL done_hold: done=%0b stim=%h required 1 %h", done_a, stim_a, s_done);
      end
   endtask

   task automatic test_single_fault();
      clear_faults();
      fault_tab[5] = 4'b0100;
      run_sequence(-10, -10);
      total++;
      if (cnt_a !== 16'd1 || flags_a !== 4'b0100) begin
         bad++; $display("FAIL single_cnt_flags: cnt=%0d flags=%b required 1 0100", cnt_a, flags_a);
      end
      total++;
      if (first_a !== 16'd5 || pass_a !== 1'b0 || done_a !== 1'b1) begin
         bad++; $display("FAIL single_first: first=%0d pass=%0b done=%0b required 5 0 1", first_a, pass_a, done_a);
      end
      total++;
      if (cnt_b !== 16'd1) begin bad++; $display("FAIL single_level_cnt: got %0d required 1", cnt_b); end
   endtask

   task automatic test_modes();
      clear_faults();
      fault_tab[3] = 4'b0001;
      fault_tab[4] = 4'b0001;
      fault_tab[5] = 4'b0001;
      fault_tab[9] = 4'b1000;
      run_sequence(-10, -10);
      total++;
      if (cnt_a !== 16'd2) begin bad++; $display("FAIL mode_edge_cnt: got %0d required 2", cnt_a); end
      total++;
      if (cnt_b !== 16'd4) begin bad++; $display("FAIL mode_level_cnt: got %0d required 4", cnt_b); end
      total++;
      if (first_a !== 16'd3 || first_b !== 16'd3) begin
         bad++; $display("FAIL mode_first: edge=%0d level=%0d required 3 3", first_a, first_b);
      end
      total++;
      if (flags_a !== 4'b1001 || flags_b !== 4'b1001) begin
         bad++; $display("FAIL mode_flags: edge=%b level=%b required 1001", flags_a, flags_b);
      end
   endtask

   task automatic test_saturation();
      clear_faults();
      sat_mode = 1'b1;
      run_sequence(-10, -10);
      sat_mode = 1'b0;
      total++;
      if (cnt_c !== 4'hF || first_c !== 4'h0) begin
         bad++; $display("FAIL sat_cnt: cnt=%h first=%0d required F 0", cnt_c, first_c);
      end
      total++;
      if (done_c !== 1'b1 || pass_c !== 1'b0 || flags_c !== 4'hF) begin
         bad++; $display("FAIL sat_verdict: done=%0b pass=%0b flags=%b required 1 0 1111", done_c, pass_c, flags_c);
      end
   endtask

   task automatic test_start_ignored();
      clear_faults();
      run_sequence(4, -10);
      total++;
      if (seq_busy != 18 || pass_a !== 1'b1) begin
         bad++; $display("FAIL start_in_run: busy_len=%0d pass=%0b required 18 1", seq_busy, pass_a);
      end
   endtask

   task automatic test_reset_midrun();
      clear_faults();
      fault_tab[2] = 4'b0010;
      run_sequence(-10, 7);
      total++;
      if (cnt_a !== 16'd1 || first_a !== 16'd2 || busy_a !== 1'b1) begin
         bad++; $display("FAIL midrun_pre: cnt=%0d first=%0d busy=%0b required 1 2 1", cnt_a, first_a, busy_a);
      end
      rst_n = 1'b0;
      #2;
      total++;
      if (cnt_a !== 16'd0 || flags_a !== 4'h0 || first_a !== 16'd0 ||
          {busy_a, done_a, pass_a} !== 3'b000 || stim_a !== 4'h1) begin
         bad++;
         $display("FAIL midrun_reset: cnt=%0d flags=%b first=%0d bdp=%b stim=%h required all 0, stim 1",
                  cnt_a, flags_a, first_a, {busy_a, done_a, pass_a}, stim_a);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_restart();
      int nbad;
      clear_faults();
      run_sequence(-10, -10);
      for (int i = 0; i < 19; i++) hist1[i] = hist[i];
      run_sequence(-10, -10);
      nbad = 0;
      for (int i = 0; i < 19; i++) if (hist[i] !== hist1[i]) nbad++;
      total++;
      if (nbad != 0) begin bad++; $display("FAIL restart_stim: %0d of 19 cycles differ, required 0", nbad); end
      total++;
      if (pass_a !== 1'b1) begin bad++; $display("FAIL restart_pass: got %0b required 1", pass_a); end
   endtask

   task automatic test_back_to_back();
      bit seen;
      start = 1'b1;
      tick();
      total++;
      if (busy_a !== 1'b1 || done_a !== 1'b0) begin
         bad++; $display("FAIL b2b_start: busy=%0b done=%0b required 1 0", busy_a, done_a);
      end
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         tick();
         if (done_a) seen = 1'b1;
      end
      tick();
      total++;
      if (!seen || busy_a !== 1'b1) begin
         bad++; $display("FAIL b2b_restart: done_seen=%0b busy=%0b required 1 1", seen, busy_a);
      end
      start = 1'b0;
      repeat (25) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      test_reset();
      test_clean_run();
      test_single_fault();
      test_modes();
      test_saturation();
      test_start_ignored();
      test_reset_midrun();
      test_restart();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rand_stim_checker
`default_nettype wire

// File: doc/rand_stim_checker.md
Name: rand_stim_checker

Overview:
Synthesizable on-chip verification block for formal top-level fabric checks.
- Drives an LFSR-generated stimulus vector into the fabric netlist and the reference benchmark.
- Compares their output vectors every cycle after a configurable warm-up.
- Reports per-bit sticky mismatch flags, a saturating error count, the first-failure cycle and a pass/done verdict.
- Sits beside the fabric wrapper; replaces a simulation-only random bench for multi-bit, multi-length runs.

Parameters:
IN_WIDTH, 1, stimulus width (1..32)
OUT_WIDTH, 1, compared output width (>=1)
CNT_WIDTH, 16, width of error counter and cycle index
RUN_CYCLES, 8192, compare cycles per run (1..2^CNT_WIDTH-1)
SKIP_CYCLES, 1, warm-up cycles after start with stimulus running and compare disabled (0 allowed)
COUNT_EDGES, 1, 1 = count only rising edges of the mismatch condition; 0 = count every mismatching cycle
LFSR_SEED, 32'h0000_0001, nonzero LFSR reload value

Ports:
clk  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin run; honoured in IDLE or DONE only
out_gfpga  in  OUT_WIDTH  fabric output vector
out_bench  in  OUT_WIDTH  reference benchmark output vector
stim  out  IN_WIDTH  stimulus to both DUTs; equals lfsr[IN_WIDTH-1:0]
busy  out  1  high in SKIP or RUN
done  out  1  high in DONE; held until next start or reset
pass  out  1  done && err_count==0
err_count  out  CNT_WIDTH  saturating mismatch count
err_flags  out  OUT_WIDTH  sticky per-bit mismatch flags
first_err_cycle  out  CNT_WIDTH  RUN index (0-based) of first mismatch; meaningful only when err_count!=0

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, lfsr=LFSR_SEED. All counters, flags, busy, done and pass are 0. stim = LFSR_SEED[IN_WIDTH-1:0].
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (taps 32'h8020_0003). Advances once per cycle in SKIP and RUN only; holds in IDLE and DONE.
- FSM IDLE -> SKIP -> RUN -> DONE -> (start) SKIP.
  - Edge with start=1 in IDLE/DONE: lfsr reloads LFSR_SEED; err_count, err_flags, first_err_cycle, cycle counter and mismatch history clear; done drops.
  - Next state is SKIP, or RUN directly if SKIP_CYCLES=0.
- SKIP lasts exactly SKIP_CYCLES cycles. RUN lasts exactly RUN_CYCLES cycles, index k=0..RUN_CYCLES-1.
- Compare: at each rising edge while in RUN, mism = out_gfpga ^ out_bench is sampled. Response to the inputs present at edge k is visible on outputs after that edge (1-cycle latency).
- Any bit set in mism: err_flags |= mism. If err_count==0 before this edge, first_err_cycle=k.
- Counting:
  - COUNT_EDGES=0: err_count +1 on each cycle with |mism.
  - COUNT_EDGES=1: +1 only when |mism is 1 and was 0 on the previous RUN cycle. History is 0 at RUN entry.
  - Saturates at all-ones with no wrap. A first-mismatch capture at saturation is not possible, since the count is nonzero.
- The edge that samples k=RUN_CYCLES-1 moves the FSM to DONE. done and pass are valid in the following cycle.
- start while busy: ignored.
- start held high in DONE: restarts every time DONE is entered, i.e. back-to-back runs.
- rst_n low mid-run: immediate return to reset values; no partial verdict is retained.
- Same seed and parameters give a bit-identical stim sequence on every run.

Decomposition:
- Shared package: FSM state enum (IDLE, SKIP, RUN, DONE), LFSR polynomial constant, default seed.
- One natural sub-module: rand_stim_lfsr (32-bit Galois LFSR with load and enable). All other logic stays in this module.

Test Plan:
1. Reset: rst_n=0 mid-simulation -> state IDLE, busy=done=pass=0, err_count=0, stim=1 (seed 1, IN_WIDTH=1). No state change while start=0.
2. Clean run (SKIP_CYCLES=2, RUN_CYCLES=16): out_gfpga=out_bench=stim.
   - busy high for 18 cycles after the start edge.
   - done=1, pass=1, err_count=0, err_flags=0.
3. Single fault (OUT_WIDTH=4): bit 2 of out_gfpga flipped at RUN k=5 only -> err_count=1, err_flags=4'b0100, first_err_cycle=5, pass=0.
4. Mode check: mismatch at k=3,4,5 and k=9.
   - COUNT_EDGES=1 -> err_count=2.
   - COUNT_EDGES=0 -> err_count=4.
   - first_err_cycle=3 in both modes.
5. Saturation (CNT_WIDTH=4, RUN_CYCLES=15, COUNT_EDGES=0): mismatch every cycle -> err_count=15 (4'hF), first_err_cycle=0, no wrap.
6. Control corner cases:
   - start pulsed during RUN -> ignored; the run length is unchanged.
   - rst_n pulsed at k=7 -> all cleared.
   - restart from DONE -> stim sequence matches the first run cycle-for-cycle.
